// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_pkg : opcode constant, J-immediate decode, queue entry |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  pred_taken;
  } fetch_entry_t;

  // Byte offset encoded in a JAL word; bit 20 is the sign.
  function automatic logic [20:0] j_imm(input logic [31:0] w);
    return {w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_queue : registered prefetch FIFO with flush, no bypass |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW:0]   r_count;
  logic            w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------+
// | fetch_unit : credit-based instruction prefetch with redirect |
// | Optional JAL prediction: FETCH_JAL_PREDICT_EN.  Rev 1.0      |
// +--------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus_4,
  output logic            instr_pred_taken,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned     c_CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] r_rsp_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_discard;

  logic [c_CW-1:0] w_q_count;
  logic [c_CW:0]   w_credit_used;
  logic [c_CW-1:0] w_outstanding_nxt;
  logic            w_q_valid;
  logic            w_req_fire;
  logic            w_rsp_accept;
  logic            w_rsp_drop;
  logic            w_pop;
  logic            w_jal_hit;
  logic [XLEN-1:0] w_jal_target;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  // Queued words plus in-flight words may never exceed the queue size.
  assign w_credit_used  = {1'b0, w_q_count} + {1'b0, r_outstanding};
  assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < DEPTH[c_CW:0]);
  assign imem_req_addr  = r_pc_f;

  assign w_req_fire   = imem_req_valid && imem_req_ready;
  assign w_rsp_drop   = imem_rsp_valid && (r_discard != '0);
  assign w_rsp_accept = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
  assign w_pop        = w_q_valid && instr_ready;

  assign w_outstanding_nxt = r_outstanding
                           + {{(c_CW-1){1'b0}}, w_req_fire}
                           - {{(c_CW-1){1'b0}}, imem_rsp_valid};

`ifdef FETCH_JAL_PREDICT_EN
  logic [20:0] w_jimm;
  assign w_jimm           = j_imm(imem_rsp_data[31:0]);
  assign w_jal_hit        = w_rsp_accept && (imem_rsp_data[6:0] == OP_JAL);
  assign w_jal_target     = r_rsp_pc + {{(XLEN-21){w_jimm[20]}}, w_jimm};
  assign instr_pred_taken = w_q_valid && w_head.pred_taken;
`else
  logic w_unused_pred;
  assign w_jal_hit        = 1'b0;
  assign w_jal_target     = r_rsp_pc;
  assign instr_pred_taken = 1'b0;
  assign w_unused_pred    = w_head.pred_taken;
`endif

  // Every word already in flight when the fetch stream is steered belongs to the old path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f        <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid) begin
        r_pc_f    <= {redirect_pc[XLEN-1:2], 2'b00};
        r_rsp_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
        r_discard <= w_outstanding_nxt;
      end else if (w_jal_hit) begin
        r_pc_f    <= {w_jal_target[XLEN-1:2], 2'b00};
        r_rsp_pc  <= {w_jal_target[XLEN-1:2], 2'b00};
        r_discard <= w_outstanding_nxt;
      end else begin
        if (w_req_fire)   r_pc_f    <= r_pc_f + c_FOUR;
        if (w_rsp_accept) r_rsp_pc  <= r_rsp_pc + c_FOUR;
        if (w_rsp_drop)   r_discard <= r_discard - 1'b1;
      end
    end
  end

  assign w_push_data = '{instr: imem_rsp_data, pc: r_rsp_pc, pred_taken: w_jal_hit};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_accept),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_q_valid),
    .o_count (w_q_count)
  );

  assign instr_valid     = w_q_valid;
  assign instr           = w_head.instr;
  assign instr_pc        = w_head.pc;
  assign instr_pc_plus_4 = w_head.pc + c_FOUR;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: random and directed stimulus checked against an in-order
// instruction-stream model with an epoch-tagged memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] JAL_P40  = 32'h0400_00EF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;
  logic        instr_pred_taken;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4),
    .instr_pred_taken(instr_pred_taken),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  logic [31:0] mq_pc[$];
  logic        mq_pred[$];

  int total = 0, bad = 0, cyc = 0, epoch = 0, last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  int n_req = 0, n_pop = 0, n_drop = 0;
  logic [31:0] exp_req = RESET_PC;
  logic        rst_next = 1'b0;
  logic        jal_en = 1'b0;
  logic [31:0] jal_addr = 32'h10;

  logic        s_req_valid, s_ivalid, s_popped, s_pop_pred;
  logic [31:0] s_req_addr, s_pc, s_pc4, s_pop_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] h;
    if (jal_en && a == jal_addr) return JAL_P40;
    h = (a ^ 32'h1357_9BDF) * 32'h9E37_79B1;
    return {h[31:7], 7'b0010011};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expired(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic step(input logic rdy, input logic drdy, input logic redir, input logic [31:0] rpc);
    logic  exp_rv;
    mreq_t r;
    int    lat;
    @(negedge clk);
    cyc++;
    rst_n          = rst_next;
    imem_req_ready = rdy;
    instr_ready    = drdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = rst_n && !redir && ((mq_pc.size() + pend.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
    chk("instr_valid", 32'(instr_valid), 32'(mq_pc.size() != 0));
    chk("pred_taken", 32'(instr_pred_taken), 32'((mq_pc.size() != 0) ? mq_pred[0] : 1'b0));
    if (mq_pc.size() != 0) begin
      chk("instr_pc", instr_pc, mq_pc[0]);
      chk("instr_word", instr, memword(mq_pc[0]));
      chk("pc_plus_4", instr_pc_plus_4, mq_pc[0] + 32'd4);
    end
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_ivalid    = instr_valid;
    s_pc        = instr_pc;
    s_pc4       = instr_pc_plus_4;
    s_popped    = instr_valid && drdy;
    s_pop_pc    = instr_pc;
    s_pop_pred  = instr_pred_taken;
    if (!rst_n) return;
    // Model state after the coming rising edge.
    if (mq_pc.size() != 0 && drdy) begin
      void'(mq_pc.pop_front());
      void'(mq_pred.pop_front());
    end
    if (s_popped) n_pop++;
    if (imem_req_valid && rdy) begin
      lat     = $urandom_range(lat_hi, lat_lo);
      r.addr  = imem_req_addr;
      r.epoch = epoch;
      r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      pend.push_back(r);
      exp_req = exp_req + 32'd4;
      n_req++;
    end
    if (imem_rsp_valid) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !redir) begin
        mq_pc.push_back(r.addr);
        if (jal_en && r.addr == jal_addr) begin
          mq_pred.push_back(1'b1);
          epoch++;
          exp_req = r.addr + 32'h40;
        end else begin
          mq_pred.push_back(1'b0);
        end
      end else begin
        n_drop++;
      end
    end
    if (redir) begin
      mq_pc.delete();
      mq_pred.delete();
      epoch++;
      exp_req = {rpc[31:2], 2'b00};
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    rst_next = 1'b0;
    pend.delete();
    mq_pc.delete();
    mq_pred.delete();
    epoch++;
    exp_req = RESET_PC;
    for (int i = 0; i < ncyc; i++) step(1'b0, 1'b0, 1'b0, '0);
    rst_next = 1'b1;
    cyc      = 0;
    last_due = 0;
    n_req    = 0;
    n_pop    = 0;
  endtask

  initial begin
    logic [31:0] boot_addrs [4];
    logic [31:0] rpc;
    int          guard;
    boot_addrs = '{32'h0, 32'h4, 32'h8, 32'hC};

    do_reset(3);
    chk("reset_req_valid", 32'(s_req_valid), 32'h0);
    chk("reset_instr_valid", 32'(s_ivalid), 32'h0);

    lat_lo = 1; lat_hi = 1;
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (c <= 4) chk("boot_addr", s_req_addr, boot_addrs[c-1]);
      if (c == 2) chk("boot_valid_c2", 32'(s_ivalid), 32'h0);
      if (c == 3) begin
        chk("boot_valid_c3", 32'(s_ivalid), 32'h1);
        chk("boot_pc", s_pc, 32'h0);
        chk("boot_pc4", s_pc4, 32'h4);
      end
    end

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("stall_req_valid", 32'(s_req_valid), 32'h0);
    chk("stall_inflight", 32'(n_req - n_pop), DEPTH);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    step(1'b0, 1'b1, 1'b1, 32'h80);
    guard = 0;
    while (pend.size() != 0 && guard < 20) begin
      step(1'b0, 1'b1, 1'b0, '0);
      guard++;
    end
    if (pend.size() != 0) expired("redir_drain");
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("redir_outstanding", 32'(pend.size()), 32'd2);
    n_drop = 0;
    step(1'b0, 1'b1, 1'b1, 32'h100);
    guard = 0;
    s_popped = 1'b0;
    while (!s_popped && guard < 30) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    if (!s_popped) expired("redir_pop");
    chk("redir_first_pc", s_pop_pc, 32'h100);
    chk("redir_dropped", 32'(n_drop), 32'd2);

    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("align_valid", 32'(s_req_valid), 32'h1);
    chk("align_addr", s_req_addr, 32'h200);

    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_addr1", s_req_addr, 32'h0000_0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

`ifdef FETCH_JAL_PREDICT_EN
    jal_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 32'h0);
    guard = 0;
    s_popped = 1'b0;
    while (!(s_popped && s_pop_pc == 32'h10) && guard < 40) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    if (!(s_popped && s_pop_pc == 32'h10)) expired("jal_head");
    chk("jal_pred", 32'(s_pop_pred), 32'h1);
    guard = 0;
    s_popped = 1'b0;
    while (!s_popped && guard < 40) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    if (!s_popped) expired("jal_next");
    chk("jal_next_pc", s_pop_pc, 32'h50);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
    jal_en = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      lat_lo = 1;
      lat_hi = 1 + (i / 500) % 4;
      rpc = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
           $urandom_range(40, 0) == 0, rpc);
    end

    do_reset(2);
    chk("midreset_req_valid", 32'(s_req_valid), 32'h0);
    chk("midreset_instr_valid", 32'(s_ivalid), 32'h0);
    for (int i = 0; i < 500; i++) begin
      lat_hi = 3;
      rpc = $urandom;
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0,
           $urandom_range(50, 0) == 0, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
